// File: rtl/jenc_pkg.sv
// -----------------------------------------------------------------------------
// jenc_pkg
// Shared types and constants for the JPEG entropy-coder back end.
//   JPEG_MARKER_BYTE : data byte that must be followed by a stuffed 0x00
//   JPEG_STUFF_BYTE  : the byte inserted after each marker-valued data byte
//   byte_t           : one stream byte
//   stuff_state_t    : byte-stuffer control state (accepting / draining a frame)
// -----------------------------------------------------------------------------
package jenc_pkg;

    localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;

    // Bytes in one input/output word, and the worst-case size of one word
    // after stuffing (every byte is 0xFF).
    localparam int WORD_BYTES = 4;
    localparam int EXP_BYTES  = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        STUFF_RUN,
        STUFF_FLUSH
    } stuff_state_t;

    function automatic logic is_marker(input byte_t b);
        return b == JPEG_MARKER_BYTE;
    endfunction

endpackage

// File: rtl/jenc_ff_stuffer_if.sv
// -----------------------------------------------------------------------------
// jenc_ff_stuffer_if
// Word stream with hold-style backpressure, used on both sides of the stuffer.
//   data   : 32-bit word, byte 0 in [31:24] (first in stream)
//   nbytes : number of valid bytes 0..4, counted from the MSB end
//   tlast  : last word of an entropy segment
//   valid  : word present
//   hold   : receiver stall; a word transfers when valid & ~hold
// master drives the word, slave drives hold.
// -----------------------------------------------------------------------------
interface jenc_ff_stuffer_if;
    import jenc_pkg::*;

    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        tlast;
    logic        valid;
    logic        hold;

    modport master (output data, nbytes, tlast, valid, input  hold);
    modport slave  (input  data, nbytes, tlast, valid, output hold);

endinterface

// File: rtl/jenc_ff_expand.sv
// -----------------------------------------------------------------------------
// jenc_ff_expand
// Combinational 0xFF stuffing of one input word.
//   data_i   : 4 bytes, byte 0 in [31:24]
//   nbytes_i : valid byte count 0..4; bytes at index >= nbytes_i are ignored
//   exp_o    : expanded bytes in stream order, unused slots are 0x00
//   len_o    : expanded length 0..8 (nbytes_i + number of valid 0xFF bytes)
// -----------------------------------------------------------------------------
module jenc_ff_expand
    import jenc_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output byte_t       exp_o [EXP_BYTES],
    output logic [3:0]  len_o
);

    byte_t                 in_bytes [WORD_BYTES];
    logic [WORD_BYTES-1:0] byte_vld;
    logic [WORD_BYTES-1:0] byte_ff;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
            assign in_bytes[gi] = data_i[31-8*gi -: 8];
            assign byte_vld[gi] = nbytes_i > 3'(gi);
            assign byte_ff[gi]  = byte_vld[gi] & is_marker(data_i[31-8*gi -: 8]);
        end
    endgenerate

    // Compact the valid bytes, opening a stuff slot after every 0xFF.
    always_comb begin
        int pos;
        for (int k = 0; k < EXP_BYTES; k++) begin
            exp_o[k] = JPEG_STUFF_BYTE;
        end
        pos = 0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_vld[i]) begin
                exp_o[pos] = in_bytes[i];
                pos        = pos + 1;
                if (byte_ff[i]) begin
                    exp_o[pos] = JPEG_STUFF_BYTE;
                    pos        = pos + 1;
                end
            end
        end
        len_o = 4'(pos);
    end

endmodule

// File: rtl/jenc_ff_stuffer.sv
// -----------------------------------------------------------------------------
// jenc_ff_stuffer
// JPEG entropy-segment byte stuffer. Inserts 0x00 after every 0xFF data byte
// and re-packs the expanded stream into full 4-byte beats; only the tlast beat
// of a frame may be partial (0..4 bytes, zero padded).
//   clk    : clock, all logic on posedge
//   reset  : synchronous active-high reset
//   in_if  : packer-side stream (slave); in_if.hold is our backpressure
//   out_if : downstream stream (master); out_if.hold stalls our output
// Parameter BUF_BYTES: accumulator depth, must be >= 11.
// -----------------------------------------------------------------------------
module jenc_ff_stuffer
    import jenc_pkg::*;
#(
    parameter int BUF_BYTES = 12
) (
    input  logic              clk,
    input  logic              reset,
    jenc_ff_stuffer_if.slave  in_if,
    jenc_ff_stuffer_if.master out_if
);

    localparam int CW = $clog2(BUF_BYTES + 1);
    typedef logic [CW-1:0] cnt_t;

    stuff_state_t state_q, state_d;
    byte_t        buf_q [BUF_BYTES];
    byte_t        buf_d [BUF_BYTES];
    cnt_t         count_q, count_d;

    logic [31:0]  out_data_q, out_data_d;
    logic [2:0]   out_nbytes_q, out_nbytes_d;
    logic         out_tlast_q, out_tlast_d;
    logic         out_valid_q, out_valid_d;

    byte_t        exp_bytes [EXP_BYTES];
    logic [3:0]   exp_len;
    logic [31:0]  head_word;
    cnt_t         pop_n;
    cnt_t         count_after_emit;
    logic         load_ok;
    logic         emit;
    logic         emit_last;
    logic         in_hold;
    logic         accept;

    jenc_ff_expand u_expand (
        .data_i   (in_if.data),
        .nbytes_i (in_if.nbytes),
        .exp_o    (exp_bytes),
        .len_o    (exp_len)
    );

    // The output register may take a new beat when empty or when its current
    // beat is leaving this cycle.
    assign load_ok = ~out_valid_q | ~out_if.hold;

    // Head of the accumulator as an MSB-first word, masked to the popped bytes.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_head
            assign head_word[31-8*gi -: 8] = (pop_n > cnt_t'(gi)) ? buf_q[gi] : JPEG_STUFF_BYTE;
        end
    endgenerate

    // Control: decide what is popped, whether input is taken, next state.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        pop_n     = '0;
        case (state_q)
            STUFF_RUN: begin
                if (load_ok && (count_q >= cnt_t'(WORD_BYTES))) begin
                    emit  = 1'b1;
                    pop_n = cnt_t'(WORD_BYTES);
                end
            end
            STUFF_FLUSH: begin
                if (load_ok) begin
                    emit = 1'b1;
                    if (count_q > cnt_t'(WORD_BYTES)) begin
                        pop_n = cnt_t'(WORD_BYTES);
                    end else begin
                        // Final beat: whatever is left, possibly nothing.
                        pop_n     = count_q;
                        emit_last = 1'b1;
                        state_d   = STUFF_RUN;
                    end
                end
            end
            default: state_d = STUFF_RUN;
        endcase

        // Space check uses the post-pop occupancy so a full beat can leave and
        // a worst-case (8-byte) word can arrive in the same cycle.
        count_after_emit = count_q - pop_n;
        in_hold = reset | (state_q == STUFF_FLUSH)
                | ((int'(count_after_emit) + EXP_BYTES) > BUF_BYTES);
        accept  = in_if.valid & ~in_hold;
        if (accept && in_if.tlast) begin
            state_d = STUFF_FLUSH;
        end
    end

    // Accumulator: shift out the popped bytes, then append at the new tail.
    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) begin
            if ((i + int'(pop_n)) < BUF_BYTES) begin
                buf_d[i] = buf_q[i + int'(pop_n)];
            end else begin
                buf_d[i] = JPEG_STUFF_BYTE;
            end
        end
        count_d = count_after_emit;
        if (accept) begin
            for (int j = 0; j < EXP_BYTES; j++) begin
                if ((j < int'(exp_len)) && ((int'(count_after_emit) + j) < BUF_BYTES)) begin
                    buf_d[int'(count_after_emit) + j] = exp_bytes[j];
                end
            end
            count_d = count_after_emit + cnt_t'(exp_len);
        end
    end

    // Output register: frozen while stalled, otherwise loads the emitted beat
    // or empties (zeroed) when there is nothing to send.
    always_comb begin
        out_data_d   = out_data_q;
        out_nbytes_d = out_nbytes_q;
        out_tlast_d  = out_tlast_q;
        out_valid_d  = out_valid_q;
        if (load_ok) begin
            out_valid_d  = emit;
            out_data_d   = emit ? head_word : 32'h0;
            out_tlast_d  = emit_last;
            out_nbytes_d = !emit ? 3'd0 : (emit_last ? 3'(pop_n) : 3'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STUFF_RUN;
            count_q      <= '0;
            out_data_q   <= '0;
            out_nbytes_q <= '0;
            out_tlast_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_nbytes_q <= out_nbytes_d;
            out_tlast_q  <= out_tlast_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign in_if.hold    = in_hold;
    assign out_if.data   = out_data_q;
    assign out_if.nbytes = out_nbytes_q;
    assign out_if.tlast  = out_tlast_q;
    assign out_if.valid  = out_valid_q;

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        count_q <= cnt_t'(BUF_BYTES));
    a_nbytes_legal : assert property (@(posedge clk) disable iff (reset)
        in_if.valid |-> (in_if.nbytes <= 3'd4));
`endif

endmodule
